// File: rtl/rv_muldiv_if.sv
// Request/response bundle for the rv_muldiv iterative M-extension unit.
// master = requester/consumer side, slave = the arithmetic unit.
interface rv_muldiv_if #(
    parameter int unsigned XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            busy;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, busy
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, busy
    );
endinterface

// File: rtl/rv_muldiv.sv
// Iterative RISC-V M-extension multiply/divide unit, one bit per cycle (XLEN cycles per op).
// Define RV_MULDIV_DIV_EN to build the restoring divider; otherwise ops 100-111 return 0.
module rv_muldiv #(
    parameter int unsigned XLEN = 32
) (
    input logic        clk,
    input logic        rst,
    rv_muldiv_if.slave bus
);
    localparam int unsigned CntW = $clog2(XLEN);

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q;
    logic [2:0]        op_q;
    logic              neg_q;
    logic [XLEN-1:0]   mcand_q;
    logic [2*XLEN-1:0] prod_q;
    logic [XLEN-1:0]   result_q;

    logic              accept;
    logic              last;
    logic              special;
    logic              a_sgn, b_sgn;
    logic              neg_d;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic [XLEN-1:0]   special_res;
    logic [XLEN-1:0]   fin_res;

    assign accept = bus.in_valid && (state_q == StIdle);
    assign last   = (cnt_q == CntW'(XLEN - 1));

    // Operand signedness by funct3; MUL low half is sign-agnostic so it is treated as unsigned.
    always_comb begin
        a_sgn = 1'b0;
        b_sgn = 1'b0;
        case (bus.op)
            3'b001: begin
                a_sgn = 1'b1;
                b_sgn = 1'b1;
            end
            3'b010: a_sgn = 1'b1;
`ifdef RV_MULDIV_DIV_EN
            3'b100, 3'b110: begin
                a_sgn = 1'b1;
                b_sgn = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    assign mag_a = (a_sgn && bus.a[XLEN-1]) ? -bus.a : bus.a;
    assign mag_b = (b_sgn && bus.b[XLEN-1]) ? -bus.b : bus.b;
    assign neg_d = (a_sgn && bus.a[XLEN-1]) ^ (b_sgn && bus.b[XLEN-1]);

`ifdef RV_MULDIV_DIV_EN
    logic div_zero, div_ovf;

    assign div_zero = (bus.b == '0);
    assign div_ovf  = !bus.op[0] && (bus.a == {1'b1, {(XLEN-1){1'b0}}}) && (bus.b == '1);
    assign special  = bus.op[2] && (div_zero || div_ovf);

    always_comb begin
        special_res = '0;
        if (div_zero) begin
            special_res = bus.op[1] ? bus.a : '1;
        end else begin
            special_res = bus.op[1] ? '0 : bus.a;
        end
    end
`else
    assign special     = bus.op[2];
    assign special_res = '0;
`endif

    // Right-shifting shift-add: high half accumulates, low half holds the multiplier bits.
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] prod_nxt;
    logic [2*XLEN-1:0] prod_sgn;
    logic [XLEN-1:0]   mul_res;

    assign mul_sum  = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
    assign prod_nxt = {mul_sum, prod_q[XLEN-1:1]};
    assign prod_sgn = neg_q ? -prod_nxt : prod_nxt;
    assign mul_res  = (op_q[1:0] == 2'b00) ? prod_sgn[XLEN-1:0] : prod_sgn[2*XLEN-1:XLEN];

`ifdef RV_MULDIV_DIV_EN
    logic [XLEN-1:0] quo_q, dvsr_q;
    logic [XLEN:0]   rem_q;
    logic            rneg_q;
    logic [XLEN:0]   rem_sh, rem_nxt;
    logic [XLEN-1:0] quo_nxt;
    logic            ge;
    logic [XLEN-1:0] div_res;
    logic            unused_div;

    assign rem_sh  = {rem_q[XLEN-1:0], quo_q[XLEN-1]};
    assign ge      = (rem_sh >= {1'b0, dvsr_q});
    assign rem_nxt = ge ? (rem_sh - {1'b0, dvsr_q}) : rem_sh;
    assign quo_nxt = {quo_q[XLEN-2:0], ge};

    // After a restore the remainder is below the divisor, so its top bit is always clear.
    assign unused_div = ^{rem_q[XLEN], rem_nxt[XLEN]};

    always_comb begin
        div_res = '0;
        if (op_q[1]) begin
            div_res = rneg_q ? -rem_nxt[XLEN-1:0] : rem_nxt[XLEN-1:0];
        end else begin
            div_res = neg_q ? -quo_nxt : quo_nxt;
        end
    end

    assign fin_res = op_q[2] ? div_res : mul_res;
`else
    logic unused_op;

    assign unused_op = op_q[2];
    assign fin_res   = mul_res;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (bus.in_valid) state_d = special ? StDone : StCalc;
            StCalc: if (last) state_d = StDone;
            StDone: if (bus.out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        bus.in_ready  = 1'b0;
        bus.busy      = 1'b0;
        bus.out_valid = 1'b0;
        unique case (state_q)
            StIdle: bus.in_ready = 1'b1;
            StCalc: bus.busy = 1'b1;
            StDone: begin
                bus.busy      = 1'b1;
                bus.out_valid = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.result = result_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        op_q    <= bus.op;
                        neg_q   <= neg_d;
                        mcand_q <= mag_a;
                        prod_q  <= {{XLEN{1'b0}}, mag_b};
                        cnt_q   <= '0;
`ifdef RV_MULDIV_DIV_EN
                        quo_q   <= mag_a;
                        dvsr_q  <= mag_b;
                        rem_q   <= '0;
                        rneg_q  <= a_sgn && bus.a[XLEN-1];
`endif
                        if (special) result_q <= special_res;
                    end
                end
                StCalc: begin
                    prod_q <= prod_nxt;
`ifdef RV_MULDIV_DIV_EN
                    quo_q  <= quo_nxt;
                    rem_q  <= rem_nxt;
`endif
                    if (last) begin
                        result_q <= fin_res;
                        cnt_q    <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_rv_muldiv.sv
// Directed bench for rv_muldiv (XLEN=32): arithmetic reference model plus per-cycle compare.
module tb_rv_muldiv;
    localparam int unsigned XLEN = 32;

    logic clk = 1'b0;
    logic rst;

    rv_muldiv_if #(.XLEN(XLEN)) bus ();

    rv_muldiv #(.XLEN(XLEN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic is_ovf(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        return op[2] && !op[0] && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    endfunction

    // Reference result from plain 64-bit arithmetic.
    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        longint          sa, sb;
        longint unsigned ua, ub;
        logic [63:0]     p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        p  = '0;
        case (op)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * longint'(ub); return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
`ifdef RV_MULDIV_DIV_EN
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (is_ovf(op, a, b)) return a;
                p = sa / sb;
                return p[31:0];
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                p = ua / ub;
                return p[31:0];
            end
            3'd6: begin
                if (b == 0) return a;
                if (is_ovf(op, a, b)) return 32'h0;
                p = sa % sb;
                return p[31:0];
            end
            3'd7: begin
                if (b == 0) return a;
                p = ua % ub;
                return p[31:0];
            end
`endif
            default: return 32'h0;
        endcase
    endfunction

    function automatic int model_lat(input logic [2:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
`ifdef RV_MULDIV_DIV_EN
        if (op[2] && (b == 0 || is_ovf(op, a, b))) return 1;
`else
        if (op[2]) return 1;
`endif
        return XLEN + 1;
    endfunction

    // Transaction-level model: idle, waiting `left` edges, or holding a result.
    logic        live   = 1'b0;
    logic        m_busy = 1'b0;
    logic        m_done = 1'b0;
    int          m_left = 0;
    logic [31:0] m_exp  = '0;

    always @(posedge clk) begin
        if (rst) begin
            live   <= 1'b1;
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_left <= 0;
        end else if (!m_busy) begin
            if (bus.in_valid) begin
                m_busy <= 1'b1;
                m_exp  <= model(bus.op, bus.a, bus.b);
                m_left <= model_lat(bus.op, bus.a, bus.b) - 1;
                m_done <= (model_lat(bus.op, bus.a, bus.b) == 1);
            end
        end else if (!m_done) begin
            m_left <= m_left - 1;
            if (m_left == 1) m_done <= 1'b1;
        end else if (bus.out_ready) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (live) begin
            chk("cmp_in_ready", 64'(bus.in_ready), 64'(!m_busy));
            chk("cmp_busy", 64'(bus.busy), 64'(m_busy));
            chk("cmp_out_valid", 64'(bus.out_valid), 64'(m_done));
            if (m_done) chk("cmp_result", 64'(bus.result), 64'(m_exp));
        end
    end

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        int          lat;
        int          hold;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] res, input int lat, input int hold);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.res = res; v.lat = lat; v.hold = hold;
        vecs.push_back(v);
    endfunction

    function automatic void add_div(input logic [2:0] op, input logic [31:0] a,
                                    input logic [31:0] b, input logic [31:0] res, input int lat);
`ifdef RV_MULDIV_DIV_EN
        add(op, a, b, res, lat, 0);
`else
        add(op, a, b, 32'h0, 1, 0);
`endif
    endfunction

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.op       = op;
        bus.a        = a;
        bus.b        = b;
        while (!bus.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("issue_timeout", 64'(n), 64'd0);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_result(input string nm, input int lat, input logic [31:0] exp,
                               input int hold, input int n0);
        int n = n0;
        while (!bus.out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (lat > 0) chk({nm, "_latency"}, 64'(n), 64'(lat));
        chk({nm, "_result"}, 64'(bus.result), 64'(exp));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({nm, "_held_result"}, 64'(bus.result), 64'(exp));
            chk({nm, "_held_in_ready"}, 64'(bus.in_ready), 64'd0);
            chk({nm, "_held_out_valid"}, 64'(bus.out_valid), 64'd1);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.op        = 3'd0;
        bus.a         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_in_ready", 64'(bus.in_ready), 64'd1);
        chk("reset_busy", 64'(bus.busy), 64'd0);
        chk("reset_out_valid", 64'(bus.out_valid), 64'd0);
        chk("reset_result", 64'(bus.result), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        add(3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, 0);
        add(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33, 0);
        add(3'd3, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33, 0);
        add(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 0);
        add(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 0);
        add(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 33, 0);
        add(3'd1, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 33, 0);
        add(3'd0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 33, 10);
        add_div(3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 33);
        add_div(3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 33);
        add_div(3'd5, 32'd100, 32'd7, 32'd14, 33);
        add_div(3'd7, 32'd100, 32'd7, 32'd2, 33);
        add_div(3'd4, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33);
        add_div(3'd6, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 33);
        add_div(3'd7, 32'hFFFF_FFFF, 32'd10, 32'd5, 33);
        add_div(3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 33);
        add_div(3'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33);
        add_div(3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
        add_div(3'd6, 32'd5, 32'd0, 32'd5, 1);
        add_div(3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
        add_div(3'd7, 32'd9, 32'd0, 32'd9, 1);
        add_div(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        add_div(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1);

        foreach (vecs[i]) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b);
            wait_result($sformatf("vec%0d_op%0d", i, vecs[i].op), vecs[i].lat, vecs[i].res,
                        vecs[i].hold, 1);
        end

        // Requests presented while busy must be ignored.
        issue(3'd0, 32'd3, 32'd5);
        bus.in_valid = 1'b1;
        bus.op       = 3'd3;
        bus.a        = 32'hFFFF_FFFF;
        bus.b        = 32'hFFFF_FFFF;
        repeat (5) @(negedge clk);
        bus.in_valid = 1'b0;
        wait_result("busy_ignore", 33, 32'd15, 0, 6);

        // Reset in the middle of a multiply aborts it.
        issue(3'd0, 32'd11, 32'd13);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_in_ready", 64'(bus.in_ready), 64'd1);
        chk("abort_busy", 64'(bus.busy), 64'd0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        chk("abort_no_out_valid", 64'(seen), 64'd0);

        // Reset wins over a simultaneous accept.
        rst          = 1'b1;
        bus.in_valid = 1'b1;
        bus.op       = 3'd0;
        bus.a        = 32'd2;
        bus.b        = 32'd3;
        @(negedge clk);
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        chk("rst_dom_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_dom_busy", 64'(bus.busy), 64'd0);
        @(negedge clk);
        chk("rst_dom_dropped", 64'(bus.busy), 64'd0);

        issue(3'd0, 32'h0000_0007, 32'hFFFF_FFFD);
        wait_result("after_reset_mul", 33, 32'hFFFF_FFEB, 0, 1);
`ifndef RV_MULDIV_DIV_EN
        issue(3'd5, 32'd100, 32'd7);
        wait_result("nodiv_divu", 1, 32'h0, 0, 1);
`endif

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
